// File: rtl/id_register_scoreboard_if.sv
// Bundle between the ID/WB pipeline control and the register scoreboard.
// The master modport drives issue/retire/read/flush; the slave modport answers with hazard status.
interface id_register_scoreboard_if #(
    parameter int TOTAL_WIDTH = 6
);
    logic                   issue_valid;
    logic                   issue_register_write;
    logic [4:0]             issue_write_register;
    logic                   retire_valid;
    logic [4:0]             retire_write_register;
    logic [4:0]             read_register_1;
    logic                   read_use_1;
    logic [4:0]             read_register_2;
    logic                   read_use_2;
    logic                   flush;
    logic                   hazard_stall;
    logic                   issue_ready;
    logic [31:0]            pending_mask;
    logic [TOTAL_WIDTH-1:0] total_inflight;
    logic                   underflow_error;

    modport master (
        output issue_valid, issue_register_write, issue_write_register,
               retire_valid, retire_write_register,
               read_register_1, read_use_1, read_register_2, read_use_2, flush,
        input  hazard_stall, issue_ready, pending_mask, total_inflight, underflow_error
    );

    modport slave (
        input  issue_valid, issue_register_write, issue_write_register,
               retire_valid, retire_write_register,
               read_register_1, read_use_1, read_register_2, read_use_2, flush,
        output hazard_stall, issue_ready, pending_mask, total_inflight, underflow_error
    );
endinterface

// File: rtl/id_register_scoreboard.sv
// Per-register saturating pending-write counters between ID issue and WB retire.
// Stall and ready are derived only from registered counters, so a retire unblocks ID one cycle later.
module id_register_scoreboard #(
    parameter int COUNT_WIDTH = 2,
    parameter int TOTAL_WIDTH = 6
) (
    input  logic                     clock,
    input  logic                     reset,
    id_register_scoreboard_if.slave  sb
);
    localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = {COUNT_WIDTH{1'b1}};

    logic [COUNT_WIDTH-1:0] count_q [32];
    logic [COUNT_WIDTH-1:0] count_d [32];
    logic [TOTAL_WIDTH-1:0] total_q, total_d;
    logic                   underflow_q, underflow_d;

    logic        issue_targets, issue_inc, retire_dec, same_register;
    logic        retire_underflow, retire_counts;
    logic [31:0] pending;

    // Entry 0 is never written, so r0 always reads back as an empty counter.
    assign issue_targets    = sb.issue_register_write && (sb.issue_write_register != 5'd0);
    assign sb.issue_ready   = !(issue_targets && (count_q[sb.issue_write_register] == COUNT_MAX));
    assign issue_inc        = sb.issue_valid && issue_targets && sb.issue_ready;
    assign retire_dec       = sb.retire_valid && (sb.retire_write_register != 5'd0);
    assign same_register    = sb.issue_write_register == sb.retire_write_register;
    assign retire_underflow = retire_dec && !(issue_inc && same_register)
                              && (count_q[sb.retire_write_register] == '0);
    assign retire_counts    = retire_dec && !retire_underflow;

    // NOTE: every variable written here gets a default first, so no path leaves a latch behind.
    always_comb begin
        count_d     = count_q;
        total_d     = total_q;
        underflow_d = underflow_q;
        if (sb.flush) begin
            for (int r = 0; r < 32; r++) count_d[r] = '0;
            total_d = '0;
        end else begin
            if (issue_inc && !(retire_dec && same_register))
                count_d[sb.issue_write_register] = count_q[sb.issue_write_register] + 1'b1;
            if (retire_dec && !(issue_inc && same_register) && !retire_underflow)
                count_d[sb.retire_write_register] = count_q[sb.retire_write_register] - 1'b1;
            if (retire_underflow) underflow_d = 1'b1;
            case ({issue_inc, retire_counts})
                2'b10:   total_d = total_q + 1'b1;
                2'b01:   total_d = total_q - 1'b1;
                default: total_d = total_q;
            endcase
        end
    end

    // NOTE: the counter array is control state, not data storage, so it takes the async reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < 32; r++) count_q[r] <= '0;
            total_q     <= '0;
            underflow_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            total_q     <= total_d;
            underflow_q <= underflow_d;
        end
    end

    always_comb begin
        pending = '0;
        for (int r = 1; r < 32; r++) pending[r] = count_q[r] != '0;
    end

    assign sb.pending_mask    = pending;
    assign sb.total_inflight  = total_q;
    assign sb.underflow_error = underflow_q;
    assign sb.hazard_stall    =
        (sb.read_use_1 && (sb.read_register_1 != 5'd0) && pending[sb.read_register_1]) ||
        (sb.read_use_2 && (sb.read_register_2 != 5'd0) && pending[sb.read_register_2]);
endmodule

// File: tb/tb_id_register_scoreboard.sv
// Directed walk through the scoreboard behaviours followed by random traffic,
// all compared against an integer-array model of pending writes per register.
module tb_id_register_scoreboard;
    localparam int COUNT_WIDTH = 2;
    localparam int TOTAL_WIDTH = 6;
    localparam int MAX_PEND    = (1 << COUNT_WIDTH) - 1;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    id_register_scoreboard_if #(.TOTAL_WIDTH(TOTAL_WIDTH)) sb_if ();

    id_register_scoreboard #(
        .COUNT_WIDTH(COUNT_WIDTH),
        .TOTAL_WIDTH(TOTAL_WIDTH)
    ) dut (
        .clock(clock),
        .reset(reset),
        .sb   (sb_if)
    );

    int pend [32];
    int inflight;
    bit underflow_seen;
    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_cmp++;
        assert (observed === expected) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < 32; r++) pend[r] = 0;
        inflight       = 0;
        underflow_seen = 0;
    endtask

    task automatic idle_inputs();
        sb_if.issue_valid           = 1'b0;
        sb_if.issue_register_write  = 1'b0;
        sb_if.issue_write_register  = 5'd0;
        sb_if.retire_valid          = 1'b0;
        sb_if.retire_write_register = 5'd0;
        sb_if.read_register_1       = 5'd0;
        sb_if.read_use_1            = 1'b0;
        sb_if.read_register_2       = 5'd0;
        sb_if.read_use_2            = 1'b0;
        sb_if.flush                 = 1'b0;
    endtask

    function automatic bit model_ready();
        int ia = int'(sb_if.issue_write_register);
        return !(sb_if.issue_register_write && ia != 0 && pend[ia] == MAX_PEND);
    endfunction

    task automatic check_outputs();
        logic [31:0] mask;
        bit stall;
        int r1, r2;
        #1;
        mask = '0;
        for (int r = 1; r < 32; r++) mask[r] = pend[r] != 0;
        r1 = int'(sb_if.read_register_1);
        r2 = int'(sb_if.read_register_2);
        stall = (sb_if.read_use_1 && r1 != 0 && pend[r1] != 0) ||
                (sb_if.read_use_2 && r2 != 0 && pend[r2] != 0);
        check("pending_mask",    sb_if.pending_mask,    mask);
        check("hazard_stall",    sb_if.hazard_stall,    stall);
        check("issue_ready",     sb_if.issue_ready,     model_ready());
        check("total_inflight",  sb_if.total_inflight,  inflight);
        check("underflow_error", sb_if.underflow_error, underflow_seen);
    endtask

    // Applies the sampled inputs of one clock edge to the model.
    task automatic model_update();
        int  ia = int'(sb_if.issue_write_register);
        int  ra = int'(sb_if.retire_write_register);
        bit  inc = sb_if.issue_valid && sb_if.issue_register_write && ia != 0 && model_ready();
        bit  dec = sb_if.retire_valid && ra != 0;
        if (sb_if.flush) begin
            for (int r = 0; r < 32; r++) pend[r] = 0;
            inflight = 0;
        end else if (!(inc && dec && ia == ra)) begin
            if (inc) begin
                pend[ia]++;
                inflight++;
            end
            if (dec) begin
                if (pend[ra] == 0) underflow_seen = 1;
                else begin
                    pend[ra]--;
                    inflight--;
                end
            end
        end
    endtask

    task automatic tick();
        check_outputs();
        @(posedge clock);
        model_update();
        @(negedge clock);
    endtask

    task automatic set_issue(input logic valid, input logic [4:0] rd);
        sb_if.issue_valid          = valid;
        sb_if.issue_register_write = 1'b1;
        sb_if.issue_write_register = rd;
    endtask

    task automatic set_retire(input logic [4:0] rd);
        sb_if.retire_valid          = 1'b1;
        sb_if.retire_write_register = rd;
    endtask

    initial begin
        model_reset();
        idle_inputs();
        check_outputs();
        check("reset_ready", sb_if.issue_ready, 1'b1);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        tick();

        // Issue r5 while ID reads it; stall persists until the cycle after retire.
        set_issue(1'b1, 5'd5);
        sb_if.read_register_1 = 5'd5;
        sb_if.read_use_1      = 1'b1;
        tick();
        set_issue(1'b0, 5'd0);
        sb_if.issue_register_write = 1'b0;
        tick();
        check("r5_stall", sb_if.hazard_stall, 1'b1);
        tick();
        set_retire(5'd5);
        tick();
        sb_if.retire_valid = 1'b0;
        check("r5_cleared", sb_if.hazard_stall, 1'b0);
        check("r5_total", sb_if.total_inflight, 0);
        tick();
        idle_inputs();

        // Saturate r7, try a fourth issue, then retire once.
        set_issue(1'b1, 5'd7);
        tick();
        tick();
        tick();
        check("r7_full_ready", sb_if.issue_ready, 1'b0);
        tick();
        check("r7_total_sat", sb_if.total_inflight, 3);
        sb_if.issue_valid = 1'b0;
        set_retire(5'd7);
        tick();
        sb_if.retire_valid = 1'b0;
        check("r7_ready_again", sb_if.issue_ready, 1'b1);
        idle_inputs();

        // Same-cycle issue and retire on r9 with one pending.
        set_issue(1'b1, 5'd9);
        tick();
        set_retire(5'd9);
        tick();
        idle_inputs();
        check("r9_total", sb_if.total_inflight, 3);
        check("r9_pending", sb_if.pending_mask[9], 1'b1);

        // r0 issue and r0 read are ignored.
        set_issue(1'b1, 5'd0);
        sb_if.read_use_1 = 1'b1;
        sb_if.read_use_2 = 1'b1;
        tick();
        check("r0_stall", sb_if.hazard_stall, 1'b0);
        check("r0_total", sb_if.total_inflight, 3);
        idle_inputs();

        // Underflow on r12 is sticky through normal traffic.
        set_retire(5'd12);
        tick();
        check("underflow_set", sb_if.underflow_error, 1'b1);
        set_retire(5'd7);
        tick();
        tick();
        set_retire(5'd9);
        tick();
        idle_inputs();
        check("underflow_sticky", sb_if.underflow_error, 1'b1);
        check("drained_total", sb_if.total_inflight, 0);

        // Flush beats a simultaneous issue.
        set_issue(1'b1, 5'd3);
        tick();
        set_issue(1'b1, 5'd4);
        tick();
        set_issue(1'b1, 5'd6);
        sb_if.flush = 1'b1;
        tick();
        idle_inputs();
        check("flush_mask", sb_if.pending_mask, 32'd0);
        check("flush_total", sb_if.total_inflight, 0);
        check("flush_keeps_underflow", sb_if.underflow_error, 1'b1);

        // Asynchronous reset between edges with r2 pending.
        set_issue(1'b1, 5'd2);
        tick();
        idle_inputs();
        sb_if.read_register_2 = 5'd2;
        sb_if.read_use_2      = 1'b1;
        #1;
        check("pre_reset_stall", sb_if.hazard_stall, 1'b1);
        #1;
        reset = 1'b0;
        #1;
        check("async_reset_mask", sb_if.pending_mask, 32'd0);
        check("async_reset_stall", sb_if.hazard_stall, 1'b0);
        check("async_reset_underflow", sb_if.underflow_error, 1'b0);
        model_reset();
        @(negedge clock);
        reset = 1'b1;
        tick();

        // Random traffic over a small register window to provoke hazards and saturation.
        for (int n = 0; n < 400; n++) begin
            sb_if.issue_valid           = 1'($urandom_range(0, 1));
            sb_if.issue_register_write  = ($urandom_range(0, 3) != 0);
            sb_if.issue_write_register  = 5'($urandom_range(0, 7));
            sb_if.retire_valid          = ($urandom_range(0, 2) == 0);
            sb_if.retire_write_register = 5'($urandom_range(0, 7));
            sb_if.read_register_1       = 5'($urandom_range(0, 7));
            sb_if.read_use_1            = 1'($urandom_range(0, 1));
            sb_if.read_register_2       = 5'($urandom_range(0, 31));
            sb_if.read_use_2            = 1'($urandom_range(0, 1));
            sb_if.flush                 = ($urandom_range(0, 49) == 0);
            tick();
        end
        idle_inputs();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/id_register_scoreboard.md
Name: id_register_scoreboard

Overview:
- Tracks in-flight register writes between the ID stage and register-file writeback, and tells ID when to stall.
- Holds one saturating pending-write counter per architectural register (r1..r31).
- Incremented when ID issues a writing instruction into EX; decremented when WB writes the register file.
- Replaces the per-stage destination compare in ID with a single registered, scalable hazard source.

Parameters:
COUNT_WIDTH, 2, width of each per-register pending counter; max pending = 2**COUNT_WIDTH-1
TOTAL_WIDTH, 6, width of the total in-flight write counter

Ports:
clock  input  1  system clock, all state updates on posedge
reset  input  1  asynchronous, active-low reset
issue_valid  input  1  ID->EX transfer fires this cycle (id_to_ex_valid && ex_allow_in)
issue_register_write  input  1  issued instruction writes a register
issue_write_register  input  5  destination of issued instruction
retire_valid  input  1  WB register-file write enable this cycle
retire_write_register  input  5  WB register-file write address
read_register_1  input  5  ID source register (rs)
read_use_1  input  1  ID instruction actually reads read_register_1
read_register_2  input  5  ID second register (rt)
read_use_2  input  1  ID instruction actually reads read_register_2
flush  input  1  synchronous clear of all pending state
hazard_stall  output  1  ID must hold: a used source has a pending write
issue_ready  output  1  issue may be accepted without counter overflow
pending_mask  output  32  bit i = counter[i] != 0; bit 0 always 0
total_inflight  output  TOTAL_WIDTH  number of tracked writes in flight
underflow_error  output  1  sticky: retire seen for a register with counter 0

Behaviour:
- Reset (reset low, asynchronous): all counters 0, total_inflight 0, underflow_error 0. Outputs are therefore: hazard_stall 0, issue_ready 1, pending_mask 0.
- Register 0 is never tracked. Issue or retire with address 0 is ignored, and read_register_x == 0 never stalls.
- issue_inc = issue_valid && issue_register_write && issue_write_register != 0 && issue_ready.
- retire_dec = retire_valid && retire_write_register != 0.
- issue_ready (combinational): 0 only when issue_register_write && issue_write_register != 0 && counter[issue_write_register] == max. Otherwise 1. ID gates issue_valid with issue_ready; an issue_valid while issue_ready == 0 changes no state.
- Counter update per edge, for register r:
  - +1 if issue_inc hits r only.
  - -1 if retire_dec hits r only.
  - Unchanged if both hit r in the same cycle.
- Same-cycle issue and retire on different registers: each is applied independently.
- Retire to r with counter[r] == 0 and no same-cycle issue to r: counter stays 0 and underflow_error is set. underflow_error clears only on reset.
- total_inflight: +1 on issue_inc, -1 on a non-underflowing retire_dec. Both in the same cycle leaves it unchanged. Invariant: total_inflight == sum of counters.
- flush has priority over same-cycle issue and retire. Next edge: all counters 0, total_inflight 0. underflow_error is unaffected.
- hazard_stall (combinational from registered counters only):
  - (read_use_1 && read_register_1 != 0 && pending_mask[read_register_1]) || (read_use_2 && read_register_2 != 0 && pending_mask[read_register_2]).
  - A same-cycle retire does not clear the stall. It clears the cycle after, when the register file already holds the value, so there is no write-then-read race.
- Latency: issue in cycle N sets pending_mask in cycle N+1. Retire in cycle N clears it in cycle N+1 (if the count reaches 0).
- Reset asserted mid-operation clears all state immediately, regardless of clock.

Test Plan:
- Reset, then idle -> pending_mask=0, total_inflight=0, hazard_stall=0, issue_ready=1, underflow_error=0.
- Issue write r5 (cycle 1); ID reads rs=5 with read_use_1=1 -> hazard_stall=1 in cycles 2..k. Retire r5 at cycle k -> hazard_stall=0 at cycle k+1, pending_mask[5]=0, total_inflight back to 0.
- Three back-to-back issues to r7 (COUNT_WIDTH=2) -> counter=3, issue_ready=0 for r7. A fourth issue_valid is ignored (total_inflight stays 3). One retire to r7 -> issue_ready=1 next cycle.
- Same cycle: issue r9 and retire r9 while counter[r9]=1 -> counter[r9] stays 1, total_inflight unchanged. Issue r0 with read rs=0 -> no state change, hazard_stall=0.
- Retire r12 with counter 0 -> underflow_error=1 and stays 1 after subsequent normal traffic. flush with pending r3,r4 plus simultaneous issue r6 -> next cycle pending_mask=0, total_inflight=0.
- Assert reset low asynchronously between edges with r2 pending -> pending_mask=0 and hazard_stall=0 before the next clock edge.
